// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared types and constants for the decode-stage hazard/bypass controller.
//   stage_tag_t : destination tag tracked for the EX shadow stage {v, rd, we, ld}
//   dst_tag_t   : destination tag tracked for MEM/WB, where load-ness no longer matters
//   BP_RA/BP_RB : bit positions of the {ra, rb} bypass/match vectors
//   ZERO_REG    : hard-wired zero register, never a forwarding source
package hazard_ctrl_pkg;

    // Tag storage width; register IDs up to this width are zero-extended into it.
    localparam int unsigned TAG_RD_W = 16;

    localparam int unsigned BP_RA = 1;
    localparam int unsigned BP_RB = 0;

    localparam logic [TAG_RD_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                v;
        logic [TAG_RD_W-1:0] rd;
        logic                we;
        logic                ld;
    } stage_tag_t;

    typedef struct packed {
        logic                v;
        logic [TAG_RD_W-1:0] rd;
        logic                we;
    } dst_tag_t;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_cmp.sv
// Purpose: compare one shadow-stage destination tag against the decode sources.
// Ports:
//   valid_i        decode holds a valid instruction
//   tag_v_i/we_i   stage tag valid / writes rd
//   tag_rd_i       stage destination ID (zero-extended)
//   ra_i, rb_i     decode source IDs (zero-extended)
//   use_ra_i/rb_i  decode instruction reads ra / rb
//   match_o        {ra_match, rb_match}
module hazard_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic                valid_i,
    input  logic                tag_v_i,
    input  logic                tag_we_i,
    input  logic [TAG_RD_W-1:0] tag_rd_i,
    input  logic [TAG_RD_W-1:0] ra_i,
    input  logic [TAG_RD_W-1:0] rb_i,
    input  logic                use_ra_i,
    input  logic                use_rb_i,
    output logic [1:0]          match_o
);

    // A stage is a candidate producer only if it writes a non-zero register.
    always_comb begin
        match_o = 2'b00;
        if (valid_i && tag_v_i && tag_we_i && (tag_rd_i != ZERO_REG)) begin
            match_o[BP_RA] = use_ra_i && (tag_rd_i == ra_i);
            match_o[BP_RB] = use_rb_i && (tag_rd_i == rb_i);
        end
    end

endmodule : hazard_cmp

// File: rtl/hazard_ctrl.sv
// Purpose: hazard and bypass controller beside the decode stage. Tracks EX/MEM/WB
//   destination tags, drives {ra, rb} bypass enables per stage, inserts a single
//   bubble on load-use, freezes on mem_stall and kills wrong-path decode on flush.
// Ports:
//   clk, rst                     clock (rising), async active-high reset
//   D_valid, D_ra, D_rb          decode valid and source IDs
//   D_use_ra, D_use_rb           decode reads ra / rb
//   D_rd, D_we, D_ld             decode destination, writes rd, is a load
//   mem_stall, flush             freeze whole pipeline / kill decode instruction
//   EX_D_bp, MEM_D_bp, WB_D_bp   combinational {ra, rb} forward enables
//   stall_D, bubble_EX           combinational decode hold / EX NOP insert
//   stall_cnt                    registered saturating count of stall_D cycles
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 D_valid,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic                 D_use_ra,
    input  logic                 D_use_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic                 D_we,
    input  logic                 D_ld,
    input  logic                 mem_stall,
    input  logic                 flush,
    output logic [1:0]           EX_D_bp,
    output logic [1:0]           MEM_D_bp,
    output logic [1:0]           WB_D_bp,
    output logic                 stall_D,
    output logic                 bubble_EX,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    stage_tag_t ex_q,  ex_d;
    dst_tag_t   mem_q, mem_d;
    dst_tag_t   wb_q,  wb_d;
    logic       flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [TAG_RD_W-1:0] ra_ext, rb_ext, rd_ext;
    logic [1:0] match_ex, match_mem, match_wb;
    logic       load_use_c, kill_c;

    assign ra_ext = TAG_RD_W'(D_ra);
    assign rb_ext = TAG_RD_W'(D_rb);
    assign rd_ext = TAG_RD_W'(D_rd);

    hazard_cmp u_cmp_ex (
        .valid_i  (D_valid),
        .tag_v_i  (ex_q.v),
        .tag_we_i (ex_q.we),
        .tag_rd_i (ex_q.rd),
        .ra_i     (ra_ext),
        .rb_i     (rb_ext),
        .use_ra_i (D_use_ra),
        .use_rb_i (D_use_rb),
        .match_o  (match_ex)
    );

    hazard_cmp u_cmp_mem (
        .valid_i  (D_valid),
        .tag_v_i  (mem_q.v),
        .tag_we_i (mem_q.we),
        .tag_rd_i (mem_q.rd),
        .ra_i     (ra_ext),
        .rb_i     (rb_ext),
        .use_ra_i (D_use_ra),
        .use_rb_i (D_use_rb),
        .match_o  (match_mem)
    );

    hazard_cmp u_cmp_wb (
        .valid_i  (D_valid),
        .tag_v_i  (wb_q.v),
        .tag_we_i (wb_q.we),
        .tag_rd_i (wb_q.rd),
        .ra_i     (ra_ext),
        .rb_i     (rb_ext),
        .use_ra_i (D_use_ra),
        .use_rb_i (D_use_rb),
        .match_o  (match_wb)
    );

    // Load results are not available in EX, so an EX load match stalls instead of forwarding.
    assign load_use_c = ex_q.ld && (match_ex != 2'b00);
    assign kill_c     = flush || flush_pend_q;

    assign EX_D_bp   = ex_q.ld ? 2'b00 : match_ex;
    assign MEM_D_bp  = match_mem;
    assign WB_D_bp   = match_wb;
    assign stall_D   = mem_stall || (load_use_c && !kill_c);
    assign bubble_EX = !mem_stall && load_use_c && !kill_c;
    assign stall_cnt = stall_cnt_q;

    // Next-state: freeze on mem_stall (remembering any flush), otherwise advance.
    always_comb begin
        ex_d         = ex_q;
        mem_d        = mem_q;
        wb_d         = wb_q;
        flush_pend_d = flush_pend_q;
        stall_cnt_d  = stall_cnt_q;

        if (mem_stall) begin
            flush_pend_d = flush_pend_q || flush;
        end else begin
            wb_d         = mem_q;
            mem_d.v      = ex_q.v;
            mem_d.rd     = ex_q.rd;
            mem_d.we     = ex_q.we;
            flush_pend_d = 1'b0;
            if (bubble_EX || kill_c || !D_valid) begin
                ex_d = '0;
            end else begin
                ex_d.v  = 1'b1;
                ex_d.rd = rd_ext;
                ex_d.we = D_we;
                ex_d.ld = D_ld;
            end
        end

        if (stall_D && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops all in-flight tags so nothing forwards across it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            flush_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            flush_pend_q <= flush_pend_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Purpose: directed self-checking bench for hazard_ctrl (table of per-cycle vectors
//   plus hand-written mem_stall, flush-pending, reset and saturation sequences).
module tb_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 3;
    localparam int unsigned NV = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          D_valid;
    logic [AW-1:0] D_ra, D_rb, D_rd;
    logic          D_use_ra, D_use_rb, D_we, D_ld;
    logic          mem_stall, flush;
    logic [1:0]    EX_D_bp, MEM_D_bp, WB_D_bp;
    logic          stall_D, bubble_EX;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          valid;
        logic [AW-1:0] ra, rb;
        logic          ura, urb;
        logic [AW-1:0] rd;
        logic          we, ld, ms, fl;
        logic [1:0]    ex, mem, wb;
        logic          stall, bub;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl [NV];

    hazard_ctrl #(.ADDR_SIZE(AW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .D_valid   (D_valid),
        .D_ra      (D_ra),
        .D_rb      (D_rb),
        .D_use_ra  (D_use_ra),
        .D_use_rb  (D_use_rb),
        .D_rd      (D_rd),
        .D_we      (D_we),
        .D_ld      (D_ld),
        .mem_stall (mem_stall),
        .flush     (flush),
        .EX_D_bp   (EX_D_bp),
        .MEM_D_bp  (MEM_D_bp),
        .WB_D_bp   (WB_D_bp),
        .stall_D   (stall_D),
        .bubble_EX (bubble_EX),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input int ra, input int rb, input logic ura,
                                input logic urb, input int rd, input logic we, input logic ld,
                                input logic ms, input logic fl, input int ex, input int mem,
                                input int wb, input logic st, input logic bu, input int cnt);
        vec_t r;
        r.valid = v;  r.ra = AW'(ra); r.rb = AW'(rb); r.ura = ura; r.urb = urb;
        r.rd = AW'(rd); r.we = we; r.ld = ld; r.ms = ms; r.fl = fl;
        r.ex = 2'(ex); r.mem = 2'(mem); r.wb = 2'(wb); r.stall = st; r.bub = bu;
        r.cnt = CW'(cnt);
        return r;
    endfunction

    task automatic drive(input logic v, input int ra, input int rb, input logic ura,
                         input logic urb, input int rd, input logic we, input logic ld,
                         input logic ms, input logic fl);
        D_valid = v; D_ra = AW'(ra); D_rb = AW'(rb); D_use_ra = ura; D_use_rb = urb;
        D_rd = AW'(rd); D_we = we; D_ld = ld; mem_stall = ms; flush = fl;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int ex, input int mem, input int wb,
                           input int st, input int bu, input int cnt);
        chk({tag, " EX_D_bp"},   int'(EX_D_bp),   ex);
        chk({tag, " MEM_D_bp"},  int'(MEM_D_bp),  mem);
        chk({tag, " WB_D_bp"},   int'(WB_D_bp),   wb);
        chk({tag, " stall_D"},   int'(stall_D),   st);
        chk({tag, " bubble_EX"}, int'(bubble_EX), bu);
        chk({tag, " stall_cnt"}, int'(stall_cnt), cnt);
    endtask

    initial begin
        // valid ra rb ura urb rd we ld ms fl | ex mem wb stall bub cnt
        tbl[0]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 5, 0, 1, 0, 7, 1, 1, 0, 0,  0, 2, 0, 0, 0, 0);
        tbl[3]  = mk(1, 5, 7, 1, 1, 0, 0, 0, 0, 0,  0, 0, 2, 1, 1, 0);
        tbl[4]  = mk(1, 5, 7, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1);
        tbl[5]  = mk(1, 7, 7, 1, 1, 0, 1, 0, 0, 0,  0, 0, 3, 0, 0, 1);
        tbl[6]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[9]  = mk(0, 9, 9, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[10] = mk(1, 9, 9, 1, 1, 0, 0, 0, 0, 0,  0, 3, 0, 0, 0, 1);
        tbl[11] = mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[12] = mk(1, 4, 0, 1, 0, 6, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        tbl[13] = mk(1, 6, 4, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Vector stream: one vector per cycle, outputs checked mid-cycle.
        for (int i = 0; i < int'(NV); i++) begin
            drive(tbl[i].valid, int'(tbl[i].ra), int'(tbl[i].rb), tbl[i].ura, tbl[i].urb,
                  int'(tbl[i].rd), tbl[i].we, tbl[i].ld, tbl[i].ms, tbl[i].fl);
            #2;
            chk_all($sformatf("vec%0d", i), int'(tbl[i].ex), int'(tbl[i].mem),
                    int'(tbl[i].wb), int'(tbl[i].stall), int'(tbl[i].bub), int'(tbl[i].cnt));
            @(negedge clk);
        end

        // mem_stall freeze with x3 in MEM, counter restarted by reset.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk_all("rst2", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 0, 1, 0, 0, 0, 0, 1, 0);
            #2;
            chk_all($sformatf("memstall%0d", i), 0, 2, 0, 1, 0, i);
            @(negedge clk);
        end
        drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        #2;
        chk_all("unfreeze", 0, 2, 0, 0, 0, 3);
        @(negedge clk);
        #2;
        chk_all("x3_in_wb", 0, 0, 2, 0, 0, 3);
        @(negedge clk);

        // flush during mem_stall applies on the first unfrozen edge.
        drive(1, 0, 0, 0, 0, 10, 1, 0, 1, 1);
        #2;
        chk_all("flush_in_stall", 0, 0, 0, 1, 0, 3);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
        #2;
        chk_all("pend_cycle", 0, 0, 0, 0, 0, 4);
        @(negedge clk);
        drive(1, 10, 0, 1, 0, 0, 0, 0, 0, 0);
        #2;
        chk_all("pend_killed", 0, 0, 0, 0, 0, 4);
        @(negedge clk);

        // Asynchronous reset mid-stream with a live EX forward.
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        @(negedge clk);
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        #2;
        chk_all("pre_rst", 2, 0, 0, 0, 0, 4);
        #1 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk_all("post_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Counter saturation at all-ones.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            #2;
            chk($sformatf("sat%0d stall_cnt", i), int'(stall_cnt), (i < 7) ? i : 7);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_ctrl
